// File: rtl/q_not_touch_if.sv
// Serial keep-alive marker stream: frame enable in, marker bit and start-of-frame pulse out.
interface q_not_touch_if;
   logic en;
   logic sig;
   logic sof;

   modport master (output en, input sig, input sof);
   modport slave  (input en, output sig, output sof);
endinterface

// File: rtl/q_not_touch.sv
// Keep-alive anchor cell: repeatedly serialises start bit, MARK_ID, CRC-8 and stop bit onto sig,
// separated by GAP idle cycles, so the enclosing logic cannot be optimised away.
module q_not_touch #(
   parameter int unsigned       ID_W    = 16,
   parameter logic [ID_W-1:0]   MARK_ID = 16'hA5C3,
   parameter int unsigned       GAP     = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   q_not_touch_if.slave   bus
);

   localparam int unsigned           CNT_W    = 8;
   localparam logic [CNT_W-1:0]      ID_LAST  = CNT_W'(ID_W - 1);
   localparam logic [CNT_W-1:0]      GAP_LAST = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0]      CRC_LAST = CNT_W'(7);
   localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_ID    = 3'd2,
      S_CRC   = 3'd3,
      S_STOP  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [7:0]        r_crc;
   logic [ID_W-1:0]   r_id_sh;
   logic              r_sig;
   logic              r_sof;

   // One bit of CRC-8, polynomial 0x07, MSB-first, no reflection.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
      logic fb;
      fb        = crc[7] ^ b;
      crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   // Frame sequencer; r_state names the field currently being driven on sig.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_crc   <= 8'h00;
         r_id_sh <= {ID_W{1'b0}};
         r_sig   <= 1'b0;
         r_sof   <= 1'b0;
      end else begin
         r_sof <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.en) begin
                  r_state <= S_START;
                  r_sig   <= 1'b1;
                  r_sof   <= 1'b1;
                  r_crc   <= 8'h00;
               end else begin
                  r_sig   <= 1'b0;
               end
            end
            S_START: begin
               r_state <= S_ID;
               r_cnt   <= ID_LAST;
               r_sig   <= MARK_ID[ID_W-1];
               r_crc   <= crc8_step(8'h00, MARK_ID[ID_W-1]);
               r_id_sh <= MARK_ID << 1'b1;
            end
            S_ID: begin
               // r_crc already covers every ID bit sent so far, including the one on sig now.
               if (r_cnt == {CNT_W{1'b0}}) begin
                  r_state <= S_CRC;
                  r_cnt   <= CRC_LAST;
                  r_sig   <= r_crc[7];
                  r_crc   <= {r_crc[6:0], 1'b0};
               end else begin
                  r_cnt   <= r_cnt - CNT_ONE;
                  r_sig   <= r_id_sh[ID_W-1];
                  r_crc   <= crc8_step(r_crc, r_id_sh[ID_W-1]);
                  r_id_sh <= r_id_sh << 1'b1;
               end
            end
            S_CRC: begin
               if (r_cnt == {CNT_W{1'b0}}) begin
                  r_state <= S_STOP;
                  r_sig   <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt - CNT_ONE;
                  r_sig   <= r_crc[7];
                  r_crc   <= {r_crc[6:0], 1'b0};
               end
            end
            S_STOP: begin
               if (GAP == 32'd0) begin
                  if (bus.en) begin
                     r_state <= S_START;
                     r_sig   <= 1'b1;
                     r_sof   <= 1'b1;
                     r_crc   <= 8'h00;
                  end else begin
                     r_state <= S_IDLE;
                     r_sig   <= 1'b0;
                  end
               end else begin
                  r_state <= S_GAP;
                  r_cnt   <= GAP_LAST;
                  r_sig   <= 1'b0;
               end
            end
            S_GAP: begin
               if (r_cnt == {CNT_W{1'b0}}) begin
                  if (bus.en) begin
                     r_state <= S_START;
                     r_sig   <= 1'b1;
                     r_sof   <= 1'b1;
                     r_crc   <= 8'h00;
                  end else begin
                     r_state <= S_IDLE;
                     r_sig   <= 1'b0;
                  end
               end else begin
                  r_cnt   <= r_cnt - CNT_ONE;
                  r_sig   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_sig   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sig = r_sig;
   assign bus.sof = r_sof;

endmodule

// File: tb/tb_q_not_touch.sv
// Scoreboard bench for q_not_touch: four parameterisations share clk/rst_n; expected
// {sig,sof} per cycle are queued by the stimulus and consumed by a negedge monitor.
module tb_q_not_touch;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   q_not_touch_if if0 ();
   q_not_touch_if if1 ();
   q_not_touch_if if2 ();
   q_not_touch_if if3 ();

   q_not_touch u_def (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   q_not_touch #(.ID_W(16), .MARK_ID(16'h0000), .GAP(4)) u_zero (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   q_not_touch #(.ID_W(16), .MARK_ID(16'hA5C3), .GAP(0)) u_gap0 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
   q_not_touch #(.ID_W(8),  .MARK_ID(8'h01),    .GAP(4)) u_w8   (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

   logic [1:0] q0[$];
   logic [1:0] q1[$];
   logic [1:0] q2[$];
   logic [1:0] q3[$];

   // Hand-computed frames: start, ID (MSB first), CRC-8 (MSB first), stop.
   logic [63:0] f_def  = 64'({1'b1, 16'hA5C3, 8'h1E, 1'b0});
   logic [63:0] f_zero = 64'({1'b1, 16'h0000, 8'h00, 1'b0});
   logic [63:0] f_w8   = 64'({1'b1, 8'h01, 8'h07, 1'b0});

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: sig/sof=%b required %b", name, $time, act, exp);
      end
   endtask

   task automatic push(input int inst, input logic [1:0] v);
      case (inst)
         0: q0.push_back(v);
         1: q1.push_back(v);
         2: q2.push_back(v);
         default: q3.push_back(v);
      endcase
   endtask

   task automatic push_idle(input int inst, input int n);
      for (int k = 0; k < n; k++) push(inst, 2'b00);
   endtask

   task automatic push_frame(input int inst, input logic [63:0] bits, input int len, input int gap);
      for (int k = 0; k < len; k++) push(inst, {bits[len-1-k], (k == 0)});
      push_idle(inst, gap);
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && n < max_cycles) begin
         @(posedge clk);
         n++;
      end
      #1;
      if ((q0.size() + q1.size() + q2.size() + q3.size()) != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d entries left, required 0",
                  q0.size() + q1.size() + q2.size() + q3.size());
         q0.delete(); q1.delete(); q2.delete(); q3.delete();
      end
   endtask

   // Monitor: compare each instance against its queued expectation every cycle.
   always @(negedge clk) begin
      if (q0.size() > 0) chk("def",  {if0.sig, if0.sof}, q0.pop_front());
      if (q1.size() > 0) chk("zero", {if1.sig, if1.sof}, q1.pop_front());
      if (q2.size() > 0) chk("gap0", {if2.sig, if2.sof}, q2.pop_front());
      if (q3.size() > 0) chk("w8",   {if3.sig, if3.sof}, q3.pop_front());
   end

   initial begin
      bit found;
      checks = 0;
      errors = 0;

      // Reset hold with en=1: all outputs stay low.
      rst_n  = 1'b0;
      if0.en = 1'b1; if1.en = 1'b1; if2.en = 1'b1; if3.en = 1'b1;
      for (int i = 0; i < 4; i++) push_idle(i, 5);
      repeat (6) @(posedge clk);
      #1;

      // Release: one idle cycle, then frames.
      rst_n = 1'b1;
      push_idle(0, 1); push_frame(0, f_def, 26, 4);  push_frame(0, f_def, 26, 4);
      push_idle(1, 1); push_frame(1, f_zero, 26, 4); push_frame(1, f_zero, 26, 4);
      push_idle(2, 1); push_frame(2, f_def, 26, 0);  push_frame(2, f_def, 26, 0);
      push_frame(2, f_def, 26, 0);
      push_idle(3, 1); push_frame(3, f_w8, 18, 4);   push_frame(3, f_w8, 18, 4);
      wait_drain(200);

      // Asynchronous reset in the middle of a start bit.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (if0.sof) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL sof_wait: sof never seen, required within 40 cycles");
      end
      chk("async_pre", {if0.sig, if0.sof}, 2'b11);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_def",  {if0.sig, if0.sof}, 2'b00);
      chk("async_gap0", {if2.sig, if2.sof}, 2'b00);

      // en toggling on the default instance; others held disabled.
      if0.en = 1'b1; if1.en = 1'b0; if2.en = 1'b0; if3.en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_def", {if0.sig, if0.sof}, 2'b00);
      rst_n = 1'b1;
      push_idle(0, 1);
      push_frame(0, f_def, 26, 4);
      push_idle(0, 6);
      push_frame(0, f_def, 26, 4);
      push_idle(1, 10);
      repeat (11) @(posedge clk);
      #1;
      if0.en = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      if0.en = 1'b1;
      wait_drain(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
